// File: rtl/thumb_fetch_queue.sv
// thumb_fetch_queue: Thumb halfword prefetch queue with 32-bit detection and branch flush
module thumb_fetch_queue #(
  parameter int DEPTH = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        f_req,
  output logic [31:0] f_addr,
  input  logic        f_ack,
  input  logic [31:0] f_rdata,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  output logic        ir_valid,
  output logic        ir_is32,
  output logic [15:0] ir_q0,
  output logic [15:0] ir_q1,
  output logic [31:0] ir_pc,
  input  logic        ir_ready
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] ONE = (AW+1)'(1);
  localparam logic [AW:0] TWO = (AW+1)'(2);
  localparam logic [AW:0] DW = (AW+1)'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state, state_nx;
  logic [15:0] q [DEPTH];
  logic [AW-1:0] rd, wr, rd1, wr1;
  logic [AW:0] count, space, n_push, n_pop;
  logic skip, take, pop;
  logic [31:0] redir, tgt_w;
  assign f_req = state != IDLE;
  assign rd1 = rd + 1'b1;
  assign wr1 = wr + 1'b1;
  assign space = DW - count;
  assign tgt_w = br_target & ~32'd3;
  assign ir_q0 = q[rd];
  assign ir_is32 = ir_q0[15:13] == 3'b111 && ir_q0[12:11] != 2'b00;
  assign ir_valid = count >= TWO || (count == ONE && !ir_is32);
  assign ir_q1 = ir_is32 ? q[rd1] : 16'h0;
  assign take = f_ack && state == REQ && !br_valid;
  assign pop = ir_valid && ir_ready && !br_valid;
  assign n_push = !take ? '0 : skip ? ONE : TWO;
  assign n_pop = !pop ? '0 : ir_is32 ? TWO : ONE;
  // next fetch state: issue only with room for a whole word, park in DISCARD when a branch orphans a request
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE ? ((space >= TWO && !br_valid) ? REQ : IDLE)
             : state == REQ  ? (f_ack ? IDLE : br_valid ? DISCARD : REQ)
             : (f_ack ? IDLE : DISCARD);
  end
  // fetch state register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  // fetch address, held stable while a request is open; redirect address parked until the orphan ack
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      f_addr <= RESET_PC & ~32'd3;
      redir <= RESET_PC & ~32'd3;
    end else begin
      if (br_valid) redir <= tgt_w;
      if (state == IDLE && br_valid) f_addr <= tgt_w;
      else if (state == REQ && f_ack) f_addr <= br_valid ? tgt_w : f_addr + 32'd4;
      else if (state == DISCARD && f_ack) f_addr <= br_valid ? tgt_w : redir;
    end
  // queue pointers, occupancy, start-halfword skip and head pc; a branch flushes everything
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      skip <= RESET_PC[1];
      ir_pc <= RESET_PC & ~32'd1;
    end else if (br_valid) begin
      rd <= '0;
      wr <= '0;
      count <= '0;
      skip <= br_target[1];
      ir_pc <= br_target & ~32'd1;
    end else begin
      rd <= rd + n_pop[AW-1:0];
      wr <= wr + n_push[AW-1:0];
      count <= count + n_push - n_pop;
      if (take) skip <= 1'b0;
      if (pop) ir_pc <= ir_pc + (ir_is32 ? 32'd4 : 32'd2);
    end
  // halfword storage: low half first unless the branch landed on the upper half
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) q <= '{default: 16'h0};
    else if (take) begin
      q[wr] <= skip ? f_rdata[31:16] : f_rdata[15:0];
      if (!skip) q[wr1] <= f_rdata[31:16];
    end
endmodule

// File: tb/tb_thumb_fetch_queue.sv
// tb_thumb_fetch_queue: randomized and directed checks against a halfword-stream model
module tb_thumb_fetch_queue;
  localparam int DEPTH = 4;
  logic clk = 0, rst_n = 0;
  logic f_req, f_ack = 0;
  logic [31:0] f_addr, f_rdata = 0, br_target = 0, ir_pc;
  logic br_valid = 0, ir_ready = 0, ir_valid, ir_is32;
  logic [15:0] ir_q0, ir_q1;
  int checks = 0, errors = 0, pops = 0, rises = 0;
  logic [31:0] wmem [256];
  logic [15:0] mq [$];
  logic [31:0] mpc, efa, prev_addr;
  bit mskip, disc, prev_req;
  int pre_size;

  thumb_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst_n(rst_n), .f_req(f_req), .f_addr(f_addr), .f_ack(f_ack), .f_rdata(f_rdata),
    .br_valid(br_valid), .br_target(br_target), .ir_valid(ir_valid), .ir_is32(ir_is32),
    .ir_q0(ir_q0), .ir_q1(ir_q1), .ir_pc(ir_pc), .ir_ready(ir_ready));

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  function automatic bit is32(input logic [15:0] h);
    return h[15:11] inside {5'b11101, 5'b11110, 5'b11111};
  endfunction

  function automatic bit exp_valid();
    return mq.size() >= 2 || (mq.size() == 1 && !is32(mq[0]));
  endfunction

  function automatic logic [15:0] rand_half();
    logic [15:0] h;
    h = 16'($urandom());
    if ($urandom_range(0, 2) == 0) h[15:11] = 5'b11101 + 5'($urandom_range(0, 2));
    return h;
  endfunction

  task automatic model_reset();
    mq.delete();
    mpc = 0;
    efa = 0;
    mskip = 0;
    disc = 0;
  endtask

  task automatic step(input bit ack, input bit rdy, input bit br, input logic [31:0] tgt);
    bit was_req, mv;
    int n;
    logic [31:0] w;
    was_req = f_req;
    f_ack = ack;
    f_rdata = wmem[f_addr[9:2]];
    ir_ready = rdy;
    br_valid = br;
    br_target = tgt;
    pre_size = mq.size();
    prev_req = f_req;
    prev_addr = f_addr;
    mv = exp_valid();
    @(posedge clk);
    if (br) begin
      mq.delete();
      mpc = {tgt[31:1], 1'b0};
      mskip = tgt[1];
      efa = {tgt[31:2], 2'b00};
      disc = was_req && !ack;
    end else begin
      n = (mv && rdy) ? (is32(mq[0]) ? 2 : 1) : 0;
      for (int i = 0; i < n; i++) void'(mq.pop_front());
      if (n > 0) pops++;
      mpc += 32'(2 * n);
      if (ack && was_req) begin
        if (disc) disc = 0;
        else begin
          w = wmem[efa[9:2]];
          if (!mskip) mq.push_back(w[15:0]);
          mq.push_back(w[31:16]);
          mskip = 0;
          efa += 4;
        end
      end
    end
    @(negedge clk);
    if (f_req && !prev_req) rises++;
    f_ack = 0;
    br_valid = 0;
  endtask

  task automatic wait_req(input bit rdy);
    int k = 0;
    while (!f_req && k < 20) begin
      step(0, rdy, 0, 0);
      k++;
    end
    checks++;
    if (f_req !== 1'b1) begin
      errors++;
      $display("FAIL wait_req f_req=%b required 1 within 20 cycles", f_req);
    end
  endtask

  task automatic test_reset();
    rst_n = 0;
    repeat (2) @(negedge clk);
    model_reset();
    checks++;
    if (f_req !== 0 || f_addr !== 0 || ir_valid !== 0 || ir_pc !== 0) begin
      errors++;
      $display("FAIL reset_state f_req=%b f_addr=%h ir_valid=%b ir_pc=%h required 0 0 0 0", f_req, f_addr, ir_valid, ir_pc);
    end
    rst_n = 1;
    @(negedge clk);
    checks++;
    if (f_req !== 1 || f_addr !== 0) begin
      errors++;
      $display("FAIL first_req f_req=%b f_addr=%h required 1 00000000", f_req, f_addr);
    end
  endtask

  task automatic test_basic();
    wmem[0] = 32'h2105_2003;
    step(1, 0, 0, 0);
    checks++;
    if (ir_valid !== 1 || ir_q0 !== 16'h2003 || ir_pc !== 0 || ir_is32 !== 0) begin
      errors++;
      $display("FAIL basic_first valid=%b q0=%h pc=%h is32=%b required 1 2003 0 0", ir_valid, ir_q0, ir_pc, ir_is32);
    end
    step(0, 1, 0, 0);
    checks++;
    if (ir_valid !== 1 || ir_q0 !== 16'h2105 || ir_pc !== 2 || ir_is32 !== 0) begin
      errors++;
      $display("FAIL basic_second valid=%b q0=%h pc=%h is32=%b required 1 2105 2 0", ir_valid, ir_q0, ir_pc, ir_is32);
    end
    step(0, 1, 0, 0);
    checks++;
    if (ir_valid !== 0 || ir_pc !== 4) begin
      errors++;
      $display("FAIL basic_empty valid=%b pc=%h required 0 4", ir_valid, ir_pc);
    end
  endtask

  task automatic test_is32();
    wmem[1] = 32'hF800_F000;
    wait_req(0);
    checks++;
    if (f_addr !== 32'h4) begin
      errors++;
      $display("FAIL is32_addr f_addr=%h required 00000004", f_addr);
    end
    step(1, 0, 0, 0);
    checks++;
    if (ir_valid !== 1 || ir_is32 !== 1 || ir_q0 !== 16'hF000 || ir_q1 !== 16'hF800 || ir_pc !== 4) begin
      errors++;
      $display("FAIL is32_head valid=%b is32=%b q0=%h q1=%h pc=%h required 1 1 F000 F800 4", ir_valid, ir_is32, ir_q0, ir_q1, ir_pc);
    end
    step(0, 1, 0, 0);
    checks++;
    if (ir_valid !== 0 || ir_pc !== 8) begin
      errors++;
      $display("FAIL is32_pop valid=%b pc=%h required 0 8", ir_valid, ir_pc);
    end
  endtask

  task automatic test_split();
    wmem[2] = 32'hF000_2001;
    wmem[3] = 32'h2002_F800;
    wait_req(0);
    step(1, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (ir_valid !== 0 || ir_pc !== 32'hA) begin
      errors++;
      $display("FAIL split_wait valid=%b pc=%h required 0 A", ir_valid, ir_pc);
    end
    wait_req(1);
    checks++;
    if (f_addr !== 32'hC) begin
      errors++;
      $display("FAIL split_addr f_addr=%h required 0000000C", f_addr);
    end
    step(1, 0, 0, 0);
    checks++;
    if (ir_valid !== 1 || ir_is32 !== 1 || ir_q0 !== 16'hF000 || ir_q1 !== 16'hF800 || ir_pc !== 32'hA) begin
      errors++;
      $display("FAIL split_join valid=%b is32=%b q0=%h q1=%h pc=%h required 1 1 F000 F800 A", ir_valid, ir_is32, ir_q0, ir_q1, ir_pc);
    end
    step(0, 1, 0, 0);
    checks++;
    if (ir_valid !== 1 || ir_q0 !== 16'h2002 || ir_pc !== 32'hE) begin
      errors++;
      $display("FAIL split_next valid=%b q0=%h pc=%h required 1 2002 E", ir_valid, ir_q0, ir_pc);
    end
  endtask

  task automatic test_branch();
    wmem[64] = 32'hBF00_4770;
    wait_req(0);
    step(0, 0, 1, 32'h102);
    checks++;
    if (f_req !== 1 || f_addr !== 32'h10 || ir_valid !== 0 || ir_pc !== 32'h102) begin
      errors++;
      $display("FAIL branch_hold f_req=%b f_addr=%h valid=%b pc=%h required 1 10 0 102", f_req, f_addr, ir_valid, ir_pc);
    end
    step(1, 0, 0, 0);
    checks++;
    if (f_req !== 0 || ir_valid !== 0) begin
      errors++;
      $display("FAIL branch_discard f_req=%b valid=%b required 0 0", f_req, ir_valid);
    end
    wait_req(0);
    checks++;
    if (f_addr !== 32'h100) begin
      errors++;
      $display("FAIL branch_addr f_addr=%h required 00000100", f_addr);
    end
    step(1, 0, 0, 0);
    checks++;
    if (ir_valid !== 1 || ir_q0 !== 16'hBF00 || ir_pc !== 32'h102 || ir_is32 !== 0) begin
      errors++;
      $display("FAIL branch_first valid=%b q0=%h pc=%h is32=%b required 1 BF00 102 0", ir_valid, ir_q0, ir_pc, ir_is32);
    end
  endtask

  task automatic test_backpressure();
    int r0;
    for (int c = 0; c < 12; c++) begin
      step(f_req, 0, 0, 0);
      checks++;
      if (f_req && !prev_req && DEPTH - pre_size < 2) begin
        errors++;
        $display("FAIL bp_issue f_req rose with %0d free entries, required >=2", DEPTH - pre_size);
      end
    end
    checks++;
    if (f_req !== 0 || ir_valid !== 1 || ir_q0 !== 16'hBF00 || ir_pc !== 32'h102) begin
      errors++;
      $display("FAIL bp_full f_req=%b valid=%b q0=%h pc=%h required 0 1 BF00 102", f_req, ir_valid, ir_q0, ir_pc);
    end
    r0 = rises;
    for (int c = 0; c < 16; c++) begin
      step(f_req, 1, 0, 0);
      checks++;
      if (ir_valid !== exp_valid() || ir_pc !== mpc || (exp_valid() && ir_q0 !== mq[0])) begin
        errors++;
        $display("FAIL bp_resume valid=%b pc=%h q0=%h required %b %h %h", ir_valid, ir_pc, ir_q0, exp_valid(), mpc, exp_valid() ? mq[0] : 16'h0);
      end
    end
    checks++;
    if (rises - r0 < 2) begin
      errors++;
      $display("FAIL bp_refetch requests=%0d required >=2", rises - r0);
    end
  endtask

  task automatic test_reset_midreq();
    wmem[0] = 32'h2105_2003;
    wait_req(0);
    rst_n = 0;
    #1;
    checks++;
    if (f_req !== 0 || f_addr !== 0 || ir_valid !== 0 || ir_pc !== 0) begin
      errors++;
      $display("FAIL midreset_async f_req=%b f_addr=%h valid=%b pc=%h required 0 0 0 0", f_req, f_addr, ir_valid, ir_pc);
    end
    @(negedge clk);
    f_ack = 1;
    f_rdata = 32'hFFFF_FFFF;
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    f_ack = 0;
    model_reset();
    checks++;
    if (f_req !== 1 || f_addr !== 0 || ir_valid !== 0 || ir_pc !== 0) begin
      errors++;
      $display("FAIL midreset_late_ack f_req=%b f_addr=%h valid=%b pc=%h required 1 0 0 0", f_req, f_addr, ir_valid, ir_pc);
    end
    step(1, 0, 0, 0);
    checks++;
    if (ir_valid !== 1 || ir_q0 !== 16'h2003 || ir_pc !== 0) begin
      errors++;
      $display("FAIL midreset_refetch valid=%b q0=%h pc=%h required 1 2003 0", ir_valid, ir_q0, ir_pc);
    end
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    logic [15:0] e0, e1;
    bit ev, e32;
    int p0;
    for (int i = 0; i < 256; i++) wmem[i] = {rand_half(), rand_half()};
    p0 = pops;
    for (int c = 0; c < 2500; c++) begin
      tgt = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : 32'($urandom_range(0, 1023));
      step(f_req && $urandom_range(0, 2) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 29) == 0, tgt);
      ev = exp_valid();
      checks++;
      if (ir_valid !== ev || ir_pc !== mpc || mq.size() > DEPTH) begin
        errors++;
        $display("FAIL rnd_state cycle %0d valid=%b pc=%h required %b %h (model holds %0d)", c, ir_valid, ir_pc, ev, mpc, mq.size());
      end
      if (ev) begin
        e0 = mq[0];
        e32 = is32(e0);
        e1 = e32 ? mq[1] : 16'h0;
        checks++;
        if (ir_q0 !== e0 || ir_is32 !== e32 || ir_q1 !== e1) begin
          errors++;
          $display("FAIL rnd_head cycle %0d q0=%h is32=%b q1=%h required %h %b %h", c, ir_q0, ir_is32, ir_q1, e0, e32, e1);
        end
      end
      if (f_req && !prev_req) begin
        checks++;
        if (DEPTH - pre_size < 2 || f_addr !== efa) begin
          errors++;
          $display("FAIL rnd_issue cycle %0d f_addr=%h free=%0d required %h >=2", c, f_addr, DEPTH - pre_size, efa);
        end
      end else if (f_req && prev_req) begin
        checks++;
        if (f_addr !== prev_addr || f_addr[1:0] !== 2'b00) begin
          errors++;
          $display("FAIL rnd_stable cycle %0d f_addr=%h required %h", c, f_addr, prev_addr);
        end
      end
    end
    checks++;
    if (pops - p0 < 200) begin
      errors++;
      $display("FAIL rnd_progress consumed=%0d required >=200", pops - p0);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) wmem[i] = 32'($urandom());
    test_reset();
    test_basic();
    test_is32();
    test_split();
    test_branch();
    test_backpressure();
    test_reset_midreq();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
